ppu_bg_fetch: RTL and testbench

- Background tile fetcher and pixel shifter for the PPU render path, one scanline at a time.
- Drives the name/attribute-table and pattern-table read addresses into the VRAM block and consumes its 1-cycle-latency read data.
- Emits a 4-bit background palette index per dot to the downstream pixel mux and palette lookup.

---
 rtl/ppu_pkg.sv | 37 +++
 rtl/ppu_bg_shifter.sv | 47 ++++
 rtl/ppu_bg_fetch.sv | 171 +++++++++++++++++
 tb/tb_ppu_bg_fetch.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/ppu_pkg.sv
// Shared definitions for the PPU background render path: FSM encoding,
// fetch-phase numbering, loopy-v field offsets and the attribute-table prefix.
package ppu_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_PREFETCH = 2'd1,
    ST_ACTIVE   = 2'd2,
    ST_DONE     = 2'd3
  } bg_state_e;

  localparam logic [2:0] P_NT     = 3'd0;
  localparam logic [2:0] P_TILE   = 3'd1;
  localparam logic [2:0] P_AT     = 3'd2;
  localparam logic [2:0] P_ATTR   = 3'd3;
  localparam logic [2:0] P_PT     = 3'd4;
  localparam logic [2:0] P_PAT    = 3'd5;
  localparam logic [2:0] P_INCX   = 3'd6;
  localparam logic [2:0] P_RELOAD = 3'd7;

  localparam int V_CX_LSB = 0;
  localparam int V_CY_LSB = 5;
  localparam int V_NT_LSB = 10;
  localparam int V_FY_LSB = 12;

  localparam logic [3:0] AT_PREFIX = 4'b1111;

  // Each attribute byte covers a 4x4-tile block; coarse_y[1]/coarse_x[1] pick the 2x2 quadrant.
  function automatic logic [1:0] at_quadrant(input logic [7:0] at_byte,
                                             input logic       cy1,
                                             input logic       cx1);
    logic [7:0] shifted;
    shifted = at_byte >> {cy1, cx1, 1'b0};
    return shifted[1:0];
  endfunction

endpackage

// File: rtl/ppu_bg_shifter.sv
// Background pixel shifters: two pattern planes and two replicated attribute
// bits, shifted once per dot and selected by the fine X scroll.
module ppu_bg_shifter
  import ppu_pkg::*;
(
  input  logic       i_ppu_clk,
  input  logic       i_ppu_rstn,
  input  logic       shift_en_i,
  input  logic       load_en_i,
  input  logic [7:0] lo_i,
  input  logic [7:0] hi_i,
  input  logic [1:0] attr_i,
  input  logic [2:0] fine_x_i,
  output logic [3:0] pix_o
);

  logic [15:0] lo_q;
  logic [15:0] hi_q;
  logic [15:0] a0_q;
  logic [15:0] a1_q;
  logic [3:0]  sel;

  // A reload shifts and refills the low byte in the same edge, so the tile
  // under display keeps moving toward bit 15 without a stall.
  always_ff @(posedge i_ppu_clk or negedge i_ppu_rstn) begin
    if (!i_ppu_rstn) begin
      lo_q <= '0;
      hi_q <= '0;
      a0_q <= '0;
      a1_q <= '0;
    end else if (load_en_i) begin
      lo_q <= {lo_q[14:7], lo_i};
      hi_q <= {hi_q[14:7], hi_i};
      a0_q <= {a0_q[14:7], {8{attr_i[0]}}};
      a1_q <= {a1_q[14:7], {8{attr_i[1]}}};
    end else if (shift_en_i) begin
      lo_q <= lo_q << 1;
      hi_q <= hi_q << 1;
      a0_q <= a0_q << 1;
      a1_q <= a1_q << 1;
    end
  end

  assign sel   = 4'd15 - {1'b0, fine_x_i};
  assign pix_o = {a1_q[sel], a0_q[sel], hi_q[sel], lo_q[sel]};

endmodule

// File: rtl/ppu_bg_fetch.sv
// Background tile fetcher: runs the 8-phase NT/AT/PT fetch schedule for one
// scanline and streams 4-bit background palette indices to the pixel mux.
module ppu_bg_fetch
  import ppu_pkg::*;
#(
  parameter int PREFETCH_TILES = 2,
  parameter int LINE_PIXELS    = 256
) (
  input  logic        i_ppu_clk,
  input  logic        i_ppu_rstn,
  input  logic        i_render_en,
  input  logic        i_line_start,
  input  logic [14:0] i_v_addr,
  input  logic [2:0]  i_fine_x,
  input  logic        i_bg_pt_sel,
  input  logic        i_bg_en,
  input  logic        i_bg_left_en,
  output logic [11:0] o_nt_addr,
  input  logic [7:0]  i_nt_rdata,
  output logic [11:0] o_pt_addr,
  input  logic [15:0] i_pt_rdata,
  output logic [3:0]  o_bg_pix,
  output logic        o_bg_pix_vld,
  output logic [7:0]  o_pix_x,
  output logic        o_busy,
  output logic        o_line_done
);

  localparam int PREFETCH_CYC = 8 * PREFETCH_TILES;
  localparam int CNT_W        = $clog2(LINE_PIXELS + PREFETCH_CYC) + 1;
  localparam logic [CNT_W-1:0] PREFETCH_LAST = CNT_W'(PREFETCH_CYC - 1);
  localparam logic [CNT_W-1:0] ACTIVE_LAST   = CNT_W'(LINE_PIXELS - 1);
  localparam logic [CNT_W-1:0] LEFT_EDGE     = CNT_W'(8);
  localparam logic [CNT_W-1:0] CNT_ONE       = CNT_W'(1);

  bg_state_e        state_q;
  logic [2:0]       phase_q, phase_d;
  logic [CNT_W-1:0] cnt_q;
  logic [4:0]       cx_q, cx_d, cy_q;
  logic [1:0]       nt_q, at2_q;
  logic             nt0_d;
  logic [2:0]       fy_q, fine_x_q;
  logic             pt_sel_q;
  logic [7:0]       tile_id_q, pt_lo_q, pt_hi_q;
  logic [11:0]      nt_addr_q, pt_addr_q;
  logic [3:0]       bg_pix_q, bg_pix_d, sh_pix;
  logic             pix_vld_q, busy_q, line_done_q;
  logic [7:0]       pix_x_q;
  logic             start, fetching, reload, left_blank;

  assign start      = i_line_start & i_render_en;
  assign fetching   = (state_q == ST_PREFETCH) || (state_q == ST_ACTIVE);
  assign reload     = fetching && (phase_q == P_RELOAD);
  assign phase_d    = phase_q + 3'd1;
  assign cx_d       = cx_q + 5'd1;
  assign nt0_d      = (cx_q == 5'd31) ? ~nt_q[0] : nt_q[0];
  assign left_blank = !i_bg_left_en && (cnt_q < LEFT_EDGE);
  assign bg_pix_d   = (!i_bg_en || left_blank) ? 4'd0 : sh_pix;

  ppu_bg_shifter u_shifter (
    .i_ppu_clk  (i_ppu_clk),
    .i_ppu_rstn (i_ppu_rstn),
    .shift_en_i (fetching),
    .load_en_i  (reload),
    .lo_i       (pt_lo_q),
    .hi_i       (pt_hi_q),
    .attr_i     (at2_q),
    .fine_x_i   (fine_x_q),
    .pix_o      (sh_pix)
  );

  // Addresses are registered one edge ahead of the phase that drives them;
  // read data is captured one phase after its address.
  always_ff @(posedge i_ppu_clk or negedge i_ppu_rstn) begin
    if (!i_ppu_rstn) begin
      state_q     <= ST_IDLE;
      phase_q     <= '0;
      cnt_q       <= '0;
      cx_q        <= '0;
      cy_q        <= '0;
      nt_q        <= '0;
      fy_q        <= '0;
      fine_x_q    <= '0;
      pt_sel_q    <= 1'b0;
      tile_id_q   <= '0;
      at2_q       <= '0;
      pt_lo_q     <= '0;
      pt_hi_q     <= '0;
      nt_addr_q   <= '0;
      pt_addr_q   <= '0;
      bg_pix_q    <= '0;
      pix_vld_q   <= 1'b0;
      pix_x_q     <= '0;
      busy_q      <= 1'b0;
      line_done_q <= 1'b0;
    end else begin
      pix_vld_q   <= 1'b0;
      line_done_q <= 1'b0;
      if (start) begin
        state_q   <= ST_PREFETCH;
        busy_q    <= 1'b1;
        phase_q   <= '0;
        cnt_q     <= '0;
        cx_q      <= i_v_addr[V_CX_LSB +: 5];
        cy_q      <= i_v_addr[V_CY_LSB +: 5];
        nt_q      <= i_v_addr[V_NT_LSB +: 2];
        fy_q      <= i_v_addr[V_FY_LSB +: 3];
        fine_x_q  <= i_fine_x;
        pt_sel_q  <= i_bg_pt_sel;
        nt_addr_q <= {i_v_addr[V_NT_LSB +: 2], i_v_addr[V_CY_LSB +: 5], i_v_addr[V_CX_LSB +: 5]};
      end else if (!i_render_en) begin
        state_q <= ST_IDLE;
        busy_q  <= 1'b0;
      end else begin
        case (state_q)
          ST_IDLE: begin
            busy_q <= 1'b0;
          end
          ST_PREFETCH, ST_ACTIVE: begin
            phase_q <= phase_d;
            cnt_q   <= cnt_q + CNT_ONE;
            if (phase_q == P_TILE) tile_id_q <= i_nt_rdata;
            if (phase_q == P_ATTR) at2_q <= at_quadrant(i_nt_rdata, cy_q[1], cx_q[1]);
            if (phase_q == P_PAT) begin
              pt_lo_q <= i_pt_rdata[7:0];
              pt_hi_q <= i_pt_rdata[15:8];
            end
            if (phase_q == P_INCX) begin
              cx_q     <= cx_d;
              nt_q[0]  <= nt0_d;
            end
            if (phase_d == P_NT) nt_addr_q <= {nt_q, cy_q, cx_q};
            if (phase_d == P_AT) nt_addr_q <= {nt_q, AT_PREFIX, cy_q[4:2], cx_q[4:2]};
            if (phase_d == P_PT) pt_addr_q <= {pt_sel_q, tile_id_q, fy_q};
            if (state_q == ST_PREFETCH) begin
              if (cnt_q == PREFETCH_LAST) begin
                state_q <= ST_ACTIVE;
                cnt_q   <= '0;
              end
            end else begin
              pix_vld_q <= 1'b1;
              bg_pix_q  <= bg_pix_d;
              pix_x_q   <= cnt_q[7:0];
              if (cnt_q == ACTIVE_LAST) begin
                state_q     <= ST_DONE;
                line_done_q <= 1'b1;
              end
            end
          end
          ST_DONE: begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
          end
          default: begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign o_nt_addr    = nt_addr_q;
  assign o_pt_addr    = pt_addr_q;
  assign o_bg_pix     = bg_pix_q;
  assign o_bg_pix_vld = pix_vld_q;
  assign o_pix_x      = pix_x_q;
  assign o_busy       = busy_q;
  assign o_line_done  = line_done_q;

endmodule

// File: tb/tb_ppu_bg_fetch.sv
// Directed bench for ppu_bg_fetch: a 1-cycle-latency VRAM model answers reads
// and each scanline's pixels are collected by x coordinate for checking.
`timescale 1ns/1ps
module tb_ppu_bg_fetch;

  logic        i_ppu_clk;
  logic        i_ppu_rstn;
  logic        i_render_en;
  logic        i_line_start;
  logic [14:0] i_v_addr;
  logic [2:0]  i_fine_x;
  logic        i_bg_pt_sel;
  logic        i_bg_en;
  logic        i_bg_left_en;
  logic [11:0] o_nt_addr;
  logic [7:0]  i_nt_rdata;
  logic [11:0] o_pt_addr;
  logic [15:0] i_pt_rdata;
  logic [3:0]  o_bg_pix;
  logic        o_bg_pix_vld;
  logic [7:0]  o_pix_x;
  logic        o_busy;
  logic        o_line_done;

  logic [7:0]  ntMem  [4096];
  logic [15:0] ptMem  [4096];
  logic [3:0]  pixBuf [256];
  int vldCount, doneCount, cycleCnt;
  int vectorCount, missCount;
  int startCyc, doneCyc, vldBefore, doneBefore, nonZero;

  ppu_bg_fetch dut (
    .i_ppu_clk    (i_ppu_clk),
    .i_ppu_rstn   (i_ppu_rstn),
    .i_render_en  (i_render_en),
    .i_line_start (i_line_start),
    .i_v_addr     (i_v_addr),
    .i_fine_x     (i_fine_x),
    .i_bg_pt_sel  (i_bg_pt_sel),
    .i_bg_en      (i_bg_en),
    .i_bg_left_en (i_bg_left_en),
    .o_nt_addr    (o_nt_addr),
    .i_nt_rdata   (i_nt_rdata),
    .o_pt_addr    (o_pt_addr),
    .i_pt_rdata   (i_pt_rdata),
    .o_bg_pix     (o_bg_pix),
    .o_bg_pix_vld (o_bg_pix_vld),
    .o_pix_x      (o_pix_x),
    .o_busy       (o_busy),
    .o_line_done  (o_line_done)
  );

  initial i_ppu_clk = 1'b0;
  always #5 i_ppu_clk = ~i_ppu_clk;

  always @(posedge i_ppu_clk) begin
    i_nt_rdata <= ntMem[o_nt_addr];
    i_pt_rdata <= ptMem[o_pt_addr];
    cycleCnt   <= cycleCnt + 1;
  end

  always @(negedge i_ppu_clk) begin
    if (o_bg_pix_vld) begin
      pixBuf[o_pix_x] <= o_bg_pix;
      vldCount        <= vldCount + 1;
    end
    if (o_line_done) doneCount <= doneCount + 1;
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectorCount++;
    if (got !== exp) begin
      missCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic stepCycles(input int n);
    repeat (n) @(negedge i_ppu_clk);
  endtask

  task automatic clearMem(input logic [15:0] ptFill);
    for (int i = 0; i < 4096; i++) begin
      ntMem[i] = 8'h00;
      ptMem[i] = ptFill;
    end
  endtask

  task automatic applyStimulus(input logic [14:0] v, input logic [2:0] fx, input logic ptSel);
    @(negedge i_ppu_clk);
    i_v_addr     = v;
    i_fine_x     = fx;
    i_bg_pt_sel  = ptSel;
    i_line_start = 1'b1;
    @(negedge i_ppu_clk);
    i_line_start = 1'b0;
    startCyc     = cycleCnt;
  endtask

  task automatic waitDone(input string tag, input int budget);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge i_ppu_clk);
      if (o_line_done) begin
        seen    = 1'b1;
        doneCyc = cycleCnt;
      end
    end
    checkOutput(tag, 32'(seen), 32'd1);
    @(negedge i_ppu_clk);
  endtask

  initial begin
    i_ppu_rstn   = 1'b0;
    i_render_en  = 1'b1;
    i_line_start = 1'b0;
    i_v_addr     = '0;
    i_fine_x     = '0;
    i_bg_pt_sel  = 1'b0;
    i_bg_en      = 1'b1;
    i_bg_left_en = 1'b1;
    clearMem(16'h0000);
    #12;
    checkOutput("reset busy", 32'(o_busy), 32'd0);
    checkOutput("reset vld", 32'(o_bg_pix_vld), 32'd0);
    checkOutput("reset nt_addr", 32'(o_nt_addr), 32'd0);
    checkOutput("reset line_done", 32'(o_line_done), 32'd0);
    @(negedge i_ppu_clk);
    i_ppu_rstn = 1'b1;

    // Basic tile: lo=F0, hi=0F gives 1,1,1,1,2,2,2,2
    ntMem[12'h000] = 8'h12;
    ptMem[12'h090] = 16'h0FF0;
    applyStimulus(15'h0000, 3'd0, 1'b0);
    checkOutput("t1 busy", 32'(o_busy), 32'd1);
    checkOutput("t1 nt addr", 32'(o_nt_addr), 32'h000);
    stepCycles(2);
    checkOutput("t1 at addr", 32'(o_nt_addr), 32'h3C0);
    stepCycles(2);
    checkOutput("t1 pt addr", 32'(o_pt_addr), 32'h090);
    stepCycles(4);
    checkOutput("t1 nt addr tile1", 32'(o_nt_addr), 32'h001);
    vldBefore = vldCount;
    waitDone("t1 done seen", 400);
    checkOutput("t1 line length", 32'(doneCyc - startCyc + 1), 32'd273);
    checkOutput("t1 vld count", 32'(vldCount - vldBefore), 32'd256);
    checkOutput("t1 idle busy", 32'(o_busy), 32'd0);
    checkOutput("t1 idle vld", 32'(o_bg_pix_vld), 32'd0);
    for (int k = 0; k < 9; k++)
      checkOutput($sformatf("t1 pix%0d", k), 32'(pixBuf[k]), (k < 4) ? 32'd1 : (k < 8) ? 32'd2 : 32'd0);

    // Attribute quadrant, pattern table select and fine_y
    clearMem(16'h0000);
    ntMem[12'h002] = 8'h05;
    ntMem[12'h3C0] = 8'hE4;
    ptMem[12'h82D] = 16'hFFFF;
    applyStimulus(15'h5002, 3'd0, 1'b1);
    checkOutput("t2 nt addr", 32'(o_nt_addr), 32'h002);
    stepCycles(2);
    checkOutput("t2 at addr", 32'(o_nt_addr), 32'h3C0);
    stepCycles(2);
    checkOutput("t2 pt addr", 32'(o_pt_addr), 32'h82D);
    waitDone("t2 done seen", 400);
    checkOutput("t2 pix0", 32'(pixBuf[0]), 32'd7);
    checkOutput("t2 pix7", 32'(pixBuf[7]), 32'd7);
    checkOutput("t2 pix8", 32'(pixBuf[8]), 32'd4);
    checkOutput("t2 pix16", 32'(pixBuf[16]), 32'd0);

    // Coarse X wrap toggles the horizontal nametable
    clearMem(16'h0000);
    applyStimulus(15'h001E, 3'd0, 1'b0);
    checkOutput("t3 nt addr 30", 32'(o_nt_addr), 32'h01E);
    stepCycles(8);
    checkOutput("t3 nt addr 31", 32'(o_nt_addr), 32'h01F);
    stepCycles(8);
    checkOutput("t3 nt addr wrap0", 32'(o_nt_addr), 32'h400);
    stepCycles(8);
    checkOutput("t3 nt addr wrap1", 32'(o_nt_addr), 32'h401);
    waitDone("t3 done seen", 400);

    // Fine X = 3
    clearMem(16'h0000);
    ntMem[12'h000] = 8'h01;
    ntMem[12'h001] = 8'h02;
    ptMem[12'h008] = 16'h00FF;
    applyStimulus(15'h0000, 3'd3, 1'b0);
    waitDone("t4 done seen", 400);
    for (int k = 0; k < 13; k++)
      checkOutput($sformatf("t4 pix%0d", k), 32'(pixBuf[k]), (k < 5) ? 32'd1 : 32'd0);

    // Left-column blanking
    clearMem(16'h00FF);
    i_bg_left_en = 1'b0;
    applyStimulus(15'h0000, 3'd0, 1'b0);
    waitDone("t5 done seen", 400);
    for (int k = 0; k < 9; k++)
      checkOutput($sformatf("t5 pix%0d", k), 32'(pixBuf[k]), (k < 8) ? 32'd0 : 32'd1);
    checkOutput("t5 pix255", 32'(pixBuf[255]), 32'd1);
    i_bg_left_en = 1'b1;

    // Background disabled: still strobed, all zero
    i_bg_en   = 1'b0;
    vldBefore = vldCount;
    applyStimulus(15'h0000, 3'd0, 1'b0);
    waitDone("t6 done seen", 400);
    nonZero = 0;
    for (int k = 0; k < 256; k++)
      if (pixBuf[k] != 4'd0) nonZero++;
    checkOutput("t6 nonzero pixels", 32'(nonZero), 32'd0);
    checkOutput("t6 vld count", 32'(vldCount - vldBefore), 32'd256);
    i_bg_en = 1'b1;

    // Mid-line restart
    applyStimulus(15'h0000, 3'd0, 1'b0);
    doneBefore = doneCount;
    stepCycles(99);
    applyStimulus(15'h0000, 3'd0, 1'b0);
    checkOutput("t7 no early done", 32'(doneCount - doneBefore), 32'd0);
    waitDone("t7 done seen", 400);
    checkOutput("t7 line length", 32'(doneCyc - startCyc + 1), 32'd273);
    checkOutput("t7 done count", 32'(doneCount - doneBefore), 32'd1);

    // Render disable mid-line
    applyStimulus(15'h0000, 3'd0, 1'b0);
    stepCycles(30);
    checkOutput("t8 vld before", 32'(o_bg_pix_vld), 32'd1);
    i_render_en = 1'b0;
    stepCycles(1);
    checkOutput("t8 busy", 32'(o_busy), 32'd0);
    checkOutput("t8 vld", 32'(o_bg_pix_vld), 32'd0);
    i_render_en = 1'b1;
    stepCycles(2);

    // Asynchronous reset mid-ACTIVE
    applyStimulus(15'h7000, 3'd0, 1'b0);
    stepCycles(40);
    checkOutput("t9 vld before", 32'(o_bg_pix_vld), 32'd1);
    i_ppu_rstn = 1'b0;
    #1;
    checkOutput("t9 vld", 32'(o_bg_pix_vld), 32'd0);
    checkOutput("t9 busy", 32'(o_busy), 32'd0);
    checkOutput("t9 bg_pix", 32'(o_bg_pix), 32'd0);
    checkOutput("t9 pix_x", 32'(o_pix_x), 32'd0);
    checkOutput("t9 nt_addr", 32'(o_nt_addr), 32'd0);
    checkOutput("t9 pt_addr", 32'(o_pt_addr), 32'd0);
    @(negedge i_ppu_clk);
    i_ppu_rstn = 1'b1;
    stepCycles(5);
    checkOutput("t9 stays idle", 32'(o_busy), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
    $finish;
  end

endmodule
